// File: rtl/mx8_rr_sched_pkg.sv
// Shared constants and state encoding for the 8-way round-robin mux scheduler.
package mx8_rr_sched_pkg;

  localparam int NREQ = 8;
  localparam int SELW = 3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/mx8.sv
// Existing 1-bit 8-to-1 mux datapath; {s2,s1,s0} selects a..h.
module mx8 (
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  input  logic e,
  input  logic f,
  input  logic g,
  input  logic h,
  input  logic s2,
  input  logic s1,
  input  logic s0,
  output logic y
);

  logic [7:0] ins;

  assign ins = {h, g, f, e, d, c, b, a};
  assign y   = ins[{s2, s1, s0}];

endmodule

// File: rtl/mx8_rr_sched_pick.sv
// Circular first-set search over 8 requests, starting at ptr and wrapping 7->0.
module rr_pick8
  import mx8_rr_sched_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [SELW-1:0] ptr,
  output logic            any,
  output logic [SELW-1:0] idx
);

  logic [SELW-1:0] k;

  // Scan from the farthest offset back to ptr so the nearest hit is written last.
  always_comb begin
    any = |req;
    idx = ptr;
    k   = ptr;
    for (int i = NREQ - 1; i >= 0; i--) begin
      k = ptr + SELW'(i);
      if (req[k]) idx = k;
    end
  end

endmodule

// File: rtl/mx8_rr_sched.sv
// Round-robin scheduler granting one of 8 requesters up to BURST cycles and steering mx8.
module mx8_rr_sched
  import mx8_rr_sched_pkg::*;
#(
  parameter int BURST = 4,
  parameter int CW    = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req,
  input  logic [7:0] d,
  output logic [7:0] gnt,
  output logic [2:0] sel,
  output logic       valid,
  output logic       y
);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [SELW-1:0] ptr;
  logic [SELW-1:0] pick_ptr;
  logic [SELW-1:0] pick_idx;
  logic            pick_any;
  logic            rel;

  assign rel = ~req[sel] | (cnt == CW'(BURST - 1));

  // While busy the arbiter already sees the post-release pointer, so a
  // release and the next grant happen on the same edge.
  assign pick_ptr = (state == BUSY) ? sel + 3'd1 : ptr;

  rr_pick8 u_pick (
    .req (req),
    .ptr (pick_ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      gnt   <= 8'h00;
      sel   <= 3'd0;
      valid <= 1'b0;
      ptr   <= 3'd0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            gnt   <= 8'd1 << pick_idx;
            sel   <= pick_idx;
            valid <= 1'b1;
            cnt   <= '0;
            state <= BUSY;
          end else begin
            gnt   <= 8'h00;
            valid <= 1'b0;
          end
        end
        BUSY: begin
          if (!rel) begin
            cnt <= cnt + 1'b1;
          end else begin
            ptr <= pick_ptr;
            if (pick_any) begin
              gnt   <= 8'd1 << pick_idx;
              sel   <= pick_idx;
              valid <= 1'b1;
              cnt   <= '0;
            end else begin
              gnt   <= 8'h00;
              valid <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= 8'h00;
          valid <= 1'b0;
        end
      endcase
    end
  end

  mx8 u_mx8 (
    .a  (d[0]),
    .b  (d[1]),
    .c  (d[2]),
    .d  (d[3]),
    .e  (d[4]),
    .f  (d[5]),
    .g  (d[6]),
    .h  (d[7]),
    .s2 (sel[2]),
    .s1 (sel[1]),
    .s0 (sel[0]),
    .y  (y)
  );

endmodule

// File: tb/tb_mx8_rr_sched.sv
// Bench for mx8_rr_sched: three instances (BURST 4, 2, 1) on shared stimulus vs. a grant-ownership model.
module tb_mx8_rr_sched;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] req = 8'h00;
  logic [7:0] d = 8'h00;

  logic [7:0] gnt_a   [3];
  logic [2:0] sel_a   [3];
  logic       valid_a [3];
  logic       y_a     [3];

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: who owns the mux, how many cycles it has held it, rotation start.
  int bursts [3] = '{4, 2, 1};
  int owner  [3];
  int held   [3];
  int last   [3];
  int rrp    [3];

  always #5 clk = ~clk;

  mx8_rr_sched #(.BURST(4), .CW(3)) dut0 (
    .clk(clk), .reset(reset), .req(req), .d(d),
    .gnt(gnt_a[0]), .sel(sel_a[0]), .valid(valid_a[0]), .y(y_a[0]));
  mx8_rr_sched #(.BURST(2), .CW(2)) dut1 (
    .clk(clk), .reset(reset), .req(req), .d(d),
    .gnt(gnt_a[1]), .sel(sel_a[1]), .valid(valid_a[1]), .y(y_a[1]));
  mx8_rr_sched #(.BURST(1), .CW(1)) dut2 (
    .clk(clk), .reset(reset), .req(req), .d(d),
    .gnt(gnt_a[2]), .sel(sel_a[2]), .valid(valid_a[2]), .y(y_a[2]));

  task automatic check(input string tag, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", tag, act, act, exp, exp, $time);
    end
  endtask

  function automatic int first_from(input logic [7:0] r, input int p);
    for (int i = 0; i < 8; i++) begin
      if (r[(p + i) % 8]) return (p + i) % 8;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int j = 0; j < 3; j++) begin
      owner[j] = -1; held[j] = 0; last[j] = 0; rrp[j] = 0;
    end
  endtask

  task automatic model_step(input logic [7:0] r);
    int k;
    for (int j = 0; j < 3; j++) begin
      if (owner[j] < 0) begin
        k = first_from(r, rrp[j]);
        if (k >= 0) begin owner[j] = k; held[j] = 1; last[j] = k; end
      end else if (!r[owner[j]] || held[j] == bursts[j]) begin
        rrp[j] = (owner[j] + 1) % 8;
        k = first_from(r, rrp[j]);
        if (k >= 0) begin owner[j] = k; held[j] = 1; last[j] = k; end
        else owner[j] = -1;
      end else begin
        held[j]++;
      end
    end
  endtask

  task automatic check_all(input string tag);
    for (int j = 0; j < 3; j++) begin
      check($sformatf("%s.gnt%0d", tag, j), int'(gnt_a[j]), owner[j] < 0 ? 0 : (1 << owner[j]));
      check($sformatf("%s.sel%0d", tag, j), int'(sel_a[j]), last[j]);
      check($sformatf("%s.valid%0d", tag, j), int'(valid_a[j]), owner[j] >= 0 ? 1 : 0);
      check($sformatf("%s.y%0d", tag, j), int'(y_a[j]), int'(d[last[j]]));
    end
  endtask

  // Inputs are applied mid-low phase; outputs are sampled 1ns after the rising edge.
  task automatic cycle(input logic [7:0] r, input logic [7:0] dv, input string tag);
    req = r;
    d   = dv;
    @(posedge clk);
    model_step(r);
    #1;
    check_all(tag);
    @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    model_reset();
    #1;
    check_all(tag);
    @(posedge clk);
    #1;
    check_all(tag);
    @(negedge clk);
    reset = 1'b0;
  endtask

  int exp_seq [8] = '{0, 0, 7, 7, 0, 0, 7, 7};

  initial begin
    model_reset();
    @(negedge clk);
    do_reset("por");

    // Reset hitting a burst in progress, then idle with no requests.
    for (int i = 0; i < 3; i++) cycle(8'hFF, 8'hA5, "burst");
    do_reset("midrst");
    for (int i = 0; i < 3; i++) cycle(8'h00, 8'h3C, "idle");

    // Sole requester 5: held, then re-granted without a valid gap.
    do_reset("r2");
    for (int i = 0; i < 10; i++) begin
      cycle(8'h20, 8'h20, "single");
      check("single.valid_dir", int'(valid_a[0]), 1);
      check("single.y_dir", int'(y_a[0]), 1);
    end

    // Requesters 0 and 7 alternate in pairs under BURST=2.
    do_reset("r3");
    for (int i = 0; i < 8; i++) begin
      cycle(8'h81, 8'h55, "rot");
      check("rot.seq", int'(sel_a[1]), exp_seq[i]);
    end

    // Requester 3 drops mid-burst while 6 is waiting.
    do_reset("r4");
    cycle(8'h48, 8'h00, "early");
    check("early.first", int'(sel_a[0]), 3);
    cycle(8'h48, 8'h00, "early");
    cycle(8'h40, 8'hFF, "early");
    cycle(8'h40, 8'hFF, "early");
    check("early.gnt_dir", int'(gnt_a[0]), 8'h40);

    // Release to idle, then the pointer skips past the old owner.
    do_reset("r5");
    cycle(8'h04, 8'h00, "toidle");
    cycle(8'h00, 8'h04, "toidle");
    check("toidle.sel_dir", int'(sel_a[0]), 2);
    check("toidle.valid_dir", int'(valid_a[0]), 0);
    cycle(8'h00, 8'h00, "toidle");
    cycle(8'h0C, 8'h00, "toidle");
    check("toidle.regrant", int'(sel_a[0]), 3);

    // BURST=1 walks through every requester.
    do_reset("r6");
    for (int i = 0; i < 10; i++) begin
      cycle(8'hFF, 8'($urandom), "b1");
      check("b1.seq", int'(sel_a[2]), i % 8);
      check("b1.onehot", int'($onehot(gnt_a[2])), 1);
    end

    // Random traffic with occasional asynchronous resets.
    do_reset("rnd0");
    for (int i = 0; i < 400; i++) begin
      logic [7:0] r;
      r = 8'($urandom) & 8'($urandom);
      if ($urandom_range(0, 9) == 0) r = 8'h00;
      cycle(r, 8'($urandom), "rnd");
      for (int j = 0; j < 3; j++)
        check("rnd.onehot0", int'($onehot0(gnt_a[j])), 1);
      if ($urandom_range(0, 60) == 0) do_reset("rndrst");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mx8_rr_sched.md
Name: mx8_rr_sched

Overview:
- Round-robin scheduler sharing one 1-bit 8-to-1 mux datapath among 8 requesters.
- Each requester drives one mux data input and raises req when its bit must reach the shared output.
- The block arbitrates requests, holds a grant for up to BURST cycles, and drives the mux selects (s2,s1,s0).
- It sits between requester logic and the existing mx8 datapath instance.

Parameters:
- BURST, 4, maximum consecutive cycles per grant; legal range 1..8.
- CW, 3, width of burst counter; must satisfy 2^CW >= BURST.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- req  input  8  request per requester; bit i = requester i
- d  input  8  data per requester; d[i] is mux input i
- gnt  output  8  one-hot grant, registered
- sel  output  3  registered mux select {s2,s1,s0} = granted index
- valid  output  1  registered; 1 while a grant is active
- y  output  1  shared datapath output = d[sel], combinational through mx8

Behaviour:
- Reset (async, immediate, also mid-burst):
  - state=IDLE, gnt=8'h00, sel=3'd0, valid=0, ptr=3'd0, cnt=0.
  - y then equals d[0].
- State IDLE:
  - If req==0, stay IDLE; outputs unchanged, valid=0, gnt=0, sel holds its last value.
  - If req!=0, pick index k = first set req bit searching circularly from ptr upward (ptr, ptr+1, ... wrapping 7->0).
  - Next edge: gnt=1<<k, sel=k, valid=1, cnt=0, state=BUSY.
  - Latency: req sampled at edge N gives grant visible after edge N (one cycle).
- State BUSY, evaluated each edge:
  - Release condition: req[sel]==0 OR cnt==BURST-1.
  - No release: cnt<=cnt+1; gnt, sel and valid hold.
  - On release: ptr<=sel+1 (mod 8, 7 wraps to 0).
    - Then re-arbitrate in the same edge using the new ptr against the current req.
    - If any bit is set: grant the winner immediately (no idle bubble), cnt<=0, stay BUSY.
    - If none: gnt<=0, valid<=0, sel holds, state<=IDLE.
  - The released requester has lowest priority on re-arbitration. If it is the only requester it is re-granted with cnt reset.
- BURST=1: release every cycle; the grant rotates each cycle among active requesters.
- A requester dropping req mid-burst releases at the next edge. The cycle in which req[sel]==0 still shows the old grant.
- Requests from non-granted requesters never preempt an active grant.
- gnt is always one-hot or zero, and gnt==(1<<sel) whenever valid=1.
- y is pure datapath with no gating. Consumers qualify y with valid.
- No X propagation: every register has a reset value and every case in the next-state logic is fully specified.

Decomposition:
- Shared package constants: NREQ=8, SELW=3, state encoding IDLE=1'b0 / BUSY=1'b1.
- Sub-module rr_pick8 (combinational):
  - Inputs req[7:0], ptr[2:0].
  - Outputs any and idx[2:0], the circular first-set search.
  - Used for both the IDLE grant and the same-edge re-arbitration.
- Datapath: existing mx8 instance, a..h = d[0]..d[7], s2/s1/s0 = sel[2]/sel[1]/sel[0], y = y.

Test Plan:
1. Reset/idle: assert reset mid-burst with req=8'hFF → gnt=0, valid=0, sel=0 immediately, without waiting for clk. After deassert with req=8'h00 → stays IDLE.
2. Single requester: req=8'h20, BURST=4 → gnt=8'h20, sel=5 one cycle later. Held 4 cycles, then re-granted to requester 5 (cnt reset), with valid continuously 1. With d=8'h20, y=1 whenever sel=5.
3. Round-robin rotation: req=8'h81 constant, BURST=2, ptr=0 → grant order 0,0,7,7,0,0,… with no idle cycles. Confirms 7→0 wrap of ptr.
4. Early release: requester 3 granted; drop req[3] after 1 cycle while req[6]=1 → next edge gnt=8'h40, sel=6, cnt=0.
5. Release to idle: sole requester 2 drops req → next edge valid=0, gnt=0, sel stays 2. Later req=8'h0C → grant goes to 3 (ptr=3), not 2.
6. BURST=1 with req=8'hFF → sel cycles 0,1,2,…,7,0 one per cycle. gnt stays one-hot throughout.
